// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode and sequencer state types for the 3-bit-opcode core
package cpu_pkg;

    typedef enum logic [2:0] {
        XOR  = 3'd0,
        BEQ  = 3'd1,
        ADDI = 3'd2,
        ANDI = 3'd3,
        LS   = 3'd4,
        LD   = 3'd5,
        ST   = 3'd6,
        J    = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } seq_state_t;

    function automatic logic is_alu_op(opcode_t op);
        return (op == XOR) || (op == ADDI) || (op == ANDI) || (op == LS);
    endfunction

endpackage

// File: rtl/seq_wdog.sv
// rtl/seq_wdog.sv - data-memory wait counter with timeout flag
module seq_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Flag rises while the (TIMEOUT-1) earlier waits are already counted,
    // so the current unacked cycle is the TIMEOUT-th one.
    assign timeout = (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !timeout) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer; CPU_SEQ_PERF_EN adds perf counters
module cpu_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic        alu_zero,
    input  logic        prog_end,
    input  logic        mem_ack,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        imem_rd,
    output logic        ir_load,
    output logic        reg_write_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  state,
    output logic [15:0] instr_retired,
    output logic [15:0] cycle_cnt
);

    import cpu_pkg::*;

    seq_state_t state_q, state_d;
    opcode_t    op;
    logic       retire;
    logic       wd_clr, wd_inc, wd_timeout;

    assign op    = opcode_t'(opcode);
    assign state = state_q;
    assign busy  = (state_q != IDLE) && (state_q != HALT) && (state_q != ERR);
    assign done  = (state_q == HALT);
    assign err   = (state_q == ERR);

    seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_clr       = 1'b0;
        pc_inc       = 1'b0;
        pc_ld        = 1'b0;
        imem_rd      = 1'b0;
        ir_load      = 1'b0;
        reg_write_en = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        retire       = 1'b0;
        wd_clr       = 1'b0;
        wd_inc       = 1'b0;
        case (state_q)
            IDLE, HALT, ERR: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_rd = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                ir_load = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                if (op == BEQ) begin
                    retire = 1'b1;
                    pc_ld  = alu_zero;
                    pc_inc = !alu_zero;
                end else if (op == J) begin
                    retire = 1'b1;
                    pc_ld  = 1'b1;
                end else if (op == LD || op == ST) begin
                    wd_clr  = 1'b1;
                    state_d = MEM;
                end else if (is_alu_op(op)) begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (op == ST);
                // An ack on the final allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    if (op == ST) begin
                        retire = 1'b1;
                        pc_inc = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (wd_timeout) begin
                    state_d = ERR;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            WB: begin
                reg_write_en = 1'b1;
                pc_inc       = 1'b1;
                retire       = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (retire) begin
            state_d = prog_end ? HALT : FETCH;
        end
    end

`ifdef CPU_SEQ_PERF_EN
    logic [15:0] ret_q, cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_q <= '0;
            cyc_q <= '0;
        end else if (pc_clr) begin
            ret_q <= '0;
            cyc_q <= '0;
        end else begin
            if (retire && ret_q != 16'hFFFF) begin
                ret_q <= ret_q + 16'd1;
            end
            if (busy && cyc_q != 16'hFFFF) begin
                cyc_q <= cyc_q + 16'd1;
            end
        end
    end

    assign instr_retired = ret_q;
    assign cycle_cnt     = cyc_q;
`else
    assign instr_retired = '0;
    assign cycle_cnt     = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with randomized programs
module tb_cpu_sequencer;

    localparam int TO = 16;

    typedef struct {
        logic [2:0] op;
        bit         z;
        int         wt;
        bit         last;
    } instr_t;

    typedef struct {
        logic [1:0] kind;
        int         lat;
        int         rw;
        int         mq;
        int         mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'd0;
    logic        alu_zero = 1'b0;
    logic        prog_end = 1'b0;
    logic        mem_ack = 1'b0;
    logic        pc_clr, pc_inc, pc_ld, imem_rd, ir_load, reg_write_en;
    logic        mem_req, mem_we, busy, done, err;
    logic [2:0]  state;
    logic [15:0] instr_retired, cycle_cnt;

    always #5 clk = ~clk;

    cpu_sequencer #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .opcode        (opcode),
        .alu_zero      (alu_zero),
        .prog_end      (prog_end),
        .mem_ack       (mem_ack),
        .pc_clr        (pc_clr),
        .pc_inc        (pc_inc),
        .pc_ld         (pc_ld),
        .imem_rd       (imem_rd),
        .ir_load       (ir_load),
        .reg_write_en  (reg_write_en),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .state         (state),
        .instr_retired (instr_retired),
        .cycle_cnt     (cycle_cnt)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: per-instruction outcome from the opcode table and MEM wait count.
    function automatic exp_t expect_of(input instr_t i);
        exp_t e;
        int   k;
        k      = i.wt + 1;
        e.kind = 2'b01;
        e.lat  = 4;
        e.rw   = 1;
        e.mq   = 0;
        e.mw   = 0;
        case (i.op)
            3'd1: begin e.lat = 3; e.rw = 0; e.kind = i.z ? 2'b10 : 2'b01; end
            3'd7: begin e.lat = 3; e.rw = 0; e.kind = 2'b10; end
            3'd6: begin e.lat = 3 + k; e.rw = 0; e.mq = k; e.mw = k; end
            3'd5: begin e.lat = 4 + k; e.mq = k; end
            default: ;
        endcase
        return e;
    endfunction

    exp_t sb[$];

    int   m_busy = 0, m_ret = 0, m_clr = 0;
    int   cyc = 0, rw = 0, mq = 0, mw = 0;
    exp_t e_pop;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) m_busy++;
            if (pc_clr) m_clr++;
            if (imem_rd) begin
                cyc = 1; rw = 0; mq = 0; mw = 0;
            end else begin
                cyc++;
            end
            rw += int'(reg_write_en);
            mq += int'(mem_req);
            mw += int'(mem_we);
            if (pc_inc || pc_ld) begin
                m_ret++;
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e_pop = sb.pop_front();
                    chk("retire_kind", 32'({pc_ld, pc_inc}), 32'(e_pop.kind));
                    chk("retire_latency", cyc, e_pop.lat);
                    chk("reg_write_pulses", rw, e_pop.rw);
                    chk("mem_req_cycles", mq, e_pop.mq);
                    chk("mem_we_cycles", mw, e_pop.mw);
                end
            end
        end
    end

    instr_t prog[16];
    int     plen = 0, pi = 0, memcnt = 0;
    instr_t cur;
    bit     inj = 1'b0;

    task add(input logic [2:0] op, input bit z, input int wt);
        prog[plen] = '{op, z, wt, 1'b0};
        plen++;
    endtask

    // Drives the memory/instruction side one cycle at a time, reacting to the DUT strobes.
    task step();
        @(posedge clk);
        #1;
        if (imem_rd) begin
            cur = prog[(pi < plen) ? pi : plen - 1];
            pi++;
            opcode   = cur.op;
            alu_zero = cur.z;
            prog_end = cur.last;
            memcnt   = 0;
            if (cur.wt < TO) sb.push_back(expect_of(cur));
        end
        if (mem_req) begin
            mem_ack = (memcnt == cur.wt);
            memcnt++;
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
        end
        start = inj && (state == 3'd3);
        if (start) inj = 1'b0;
    endtask

    task run_prog(input bit inject);
        int     b0, r0, c0, exp_busy, exp_ret, n;
        bit     exp_err;
        exp_t   t;
        b0 = m_busy; r0 = m_ret; c0 = m_clr;
        exp_busy = 0; exp_ret = 0; exp_err = 1'b0;
        prog[plen-1].last = 1'b1;
        for (int i = 0; i < plen; i++) begin
            if (prog[i].wt >= TO) begin
                exp_err = 1'b1;
                exp_busy += 3 + TO;
            end else begin
                t = expect_of(prog[i]);
                exp_busy += t.lat;
                exp_ret++;
            end
        end
        pi  = 0;
        inj = inject;
        step();
        start = 1'b1;
        @(negedge clk);
        chk("pc_clr_on_start", 32'(pc_clr), 32'd1);
        step();
        chk("fetch_after_start", 32'(state), 32'd1);
        chk("status_after_start", 32'({done, err, busy}), 32'b001);
        n = 0;
        while (!(done || err) && n < 3000) begin
            step();
            n++;
        end
        chk("prog_completes", 32'(n < 3000), 32'd1);
        chk("end_status", 32'({done, err}), exp_err ? 32'b01 : 32'b10);
        chk("mem_req_after_end", 32'(mem_req), 32'd0);
        chk("busy_cycles", m_busy - b0, exp_busy);
        chk("retire_count", m_ret - r0, exp_ret);
        chk("pc_clr_count", m_clr - c0, 32'd1);
`ifdef CPU_SEQ_PERF_EN
        chk("perf_instr_retired", 32'(instr_retired), exp_ret);
        chk("perf_cycle_cnt", 32'(cycle_cnt), exp_busy);
`else
        chk("perf_instr_retired", 32'(instr_retired), 32'd0);
        chk("perf_cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_strobes", 32'({pc_clr, pc_inc, pc_ld, imem_rd, ir_load, reg_write_en, mem_req, mem_we}), 32'd0);
        chk("reset_status", 32'({busy, done, err}), 32'd0);
        chk("reset_counters", {instr_retired, cycle_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'(state), 32'd0);

        plen = 0; add(3'd2, 1'b0, 0); add(3'd0, 1'b0, 0); run_prog(1'b0);
        plen = 0; add(3'd1, 1'b1, 0); add(3'd1, 1'b0, 0); run_prog(1'b0);
        plen = 0; add(3'd6, 1'b0, 3); run_prog(1'b1);
        plen = 0; add(3'd5, 1'b0, TO - 1); run_prog(1'b0);
        plen = 0; add(3'd5, 1'b0, TO); run_prog(1'b0);

        for (int p = 0; p < 10; p++) begin
            plen = 0;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                add(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3)));
            end
            run_prog(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while a store is waiting for its ack.
        plen = 0; add(3'd6, 1'b0, TO - 1); prog[0].last = 1'b1; pi = 0;
        step();
        start = 1'b1;
        step();
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk("reached_mem", 32'(mem_req), 32'd1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mem_req", 32'(mem_req), 32'd0);
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_status", 32'({busy, done, err}), 32'd0);
        chk("async_reset_counters", {instr_retired, cycle_cnt}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 32'(state), 32'd0);

        plen = 0; add(3'd2, 1'b0, 0); add(3'd7, 1'b0, 0); add(3'd6, 1'b0, 1); run_prog(1'b0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

endmodule
